// File: rtl/rv32e_pkg.sv
// Shared RV32E definitions: data width, bubble encoding, instruction field
// positions and the major opcodes recognised by decode.
package rv32e_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = '0;

    localparam int unsigned OpcodeLsb = 0;
    localparam int unsigned OpcodeMsb = 6;
    localparam int unsigned Funct3Lsb = 12;
    localparam int unsigned Funct3Msb = 14;
    localparam int unsigned Funct7Lsb = 25;
    localparam int unsigned Funct7Msb = 31;

    typedef enum logic [6:0] {
        OpLoad   = 7'b0000011,
        OpImm    = 7'b0010011,
        OpAuipc  = 7'b0010111,
        OpStore  = 7'b0100011,
        OpReg    = 7'b0110011,
        OpLui    = 7'b0110111,
        OpBranch = 7'b1100011,
        OpJalr   = 7'b1100111,
        OpJal    = 7'b1101111,
        OpSystem = 7'b1110011
    } opcode_e;

    function automatic logic [6:0] instr_opcode(input logic [XLEN-1:0] instr);
        return instr[OpcodeMsb:OpcodeLsb];
    endfunction

    function automatic logic [2:0] instr_funct3(input logic [XLEN-1:0] instr);
        return instr[Funct3Msb:Funct3Lsb];
    endfunction

    function automatic logic [6:0] instr_funct7(input logic [XLEN-1:0] instr);
        return instr[Funct7Msb:Funct7Lsb];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect from execute
// and the decode-side handshake with pre-split instruction fields.
interface fetch_unit_if;
    import rv32e_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
               opcode, funct3, funct7,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
               opcode, funct3, funct7,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid,
               redirect_pc, if_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO with flush; flush overrides push and pop.
module fetch_queue #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [1:0]       count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = !rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/fetch_unit.sv
// RV32E instruction fetch: PC, credit-limited imem requests, 2-entry
// instruction queue towards decode, and redirect flush with stale-response drop.
module fetch_unit
    import rv32e_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    // Outstanding count can exceed 2 while stale responses are still draining.
    localparam int unsigned CntW    = 3;
    localparam int unsigned CreditW = CntW + 1;

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CntW-1:0]   inflight_q, inflight_d;
    logic [CntW-1:0]   drop_q, drop_d;
    logic [CreditW-1:0] credits_used;
    logic              req_valid, req_fire, rsp_keep, iq_pop;
    logic [1:0]        iq_count, af_count;
    logic              iq_empty, iq_full, af_empty, af_full;
    logic [2*XLEN-1:0] iq_head;
    logic [XLEN-1:0]   af_head, if_instr;

    assign credits_used = {1'b0, inflight_q} + CreditW'(iq_count) - {1'b0, drop_q};
    assign req_valid    = !rst && !bus.redirect_valid && (credits_used < CreditW'(2));
    assign req_fire     = req_valid && bus.imem_req_ready;
    assign rsp_keep     = bus.imem_rsp_valid && (drop_q == '0) && !bus.redirect_valid;
    assign iq_pop       = !iq_empty && bus.if_ready && !bus.redirect_valid;

    always_comb begin
        pc_d       = pc_q;
        inflight_d = inflight_q + CntW'(req_fire) - CntW'(bus.imem_rsp_valid);
        drop_d     = drop_q;
        if (bus.redirect_valid) begin
            pc_d   = {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_d = inflight_q - CntW'(bus.imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(4);
            end
            if (bus.imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    // Holds addresses of kept requests only; dropped responses never pop it.
    fetch_queue #(.Width(XLEN)) u_addr_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.redirect_valid),
        .push_i     (req_fire),
        .push_data_i(pc_q),
        .pop_i      (rsp_keep),
        .head_o     (af_head),
        .count_o    (af_count),
        .empty_o    (af_empty),
        .full_o     (af_full)
    );

    fetch_queue #(.Width(2 * XLEN)) u_instr_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (bus.redirect_valid),
        .push_i     (rsp_keep),
        .push_data_i({bus.imem_rsp_data, af_head}),
        .pop_i      (iq_pop),
        .head_o     (iq_head),
        .count_o    (iq_count),
        .empty_o    (iq_empty),
        .full_o     (iq_full)
    );

    assign if_instr           = iq_empty ? INSTR_NOP : iq_head[2*XLEN-1:XLEN];
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.if_valid       = !iq_empty;
    assign bus.if_instr       = if_instr;
    assign bus.if_pc          = iq_empty ? '0 : iq_head[XLEN-1:0];
    assign bus.opcode         = instr_opcode(if_instr);
    assign bus.funct3         = instr_funct3(if_instr);
    assign bus.funct7         = instr_funct7(if_instr);

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(rsp_keep && iq_full));
    a_no_addr_overflow: assert property (@(posedge clk) disable iff (rst) !(req_fire && af_full));
    a_keep_has_addr: assert property (@(posedge clk) disable iff (rst) !(rsp_keep && af_empty));
    a_addr_tracks: assert property (@(posedge clk) disable iff (rst)
        CntW'(af_count) == (inflight_q - drop_q));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every cycle
// plus literal expectations for the reset, stall, redirect and wrap scenarios.
module tb_fetch_unit;
    import rv32e_pkg::*;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] addr;
        logic        keep;
    } ot_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } dq_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RstPc)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] pend[$];
    ot_t         m_ot[$];
    dq_t         m_dq[$];
    logic [31:0] m_pc;
    logic        m_fire;
    ot_t         m_o;
    logic [31:0] e_instr, e_pc;
    logic        seen, hit;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h00C0_FFEE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Requests allowed while fewer than 2 words are queued or kept-in-flight.
    function automatic logic exp_req_valid();
        int kept = 0;
        foreach (m_ot[i]) if (m_ot[i].keep) kept++;
        return !rst && !bus.redirect_valid && ((kept + m_dq.size()) < 2);
    endfunction

    // Instruction memory: responds one cycle after acceptance unless held.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
        end else begin
            if (bus.imem_rsp_valid) void'(pend.pop_front());
            if (bus.imem_req_valid && bus.imem_req_ready) pend.push_back(bus.imem_req_addr);
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RstPc;
            m_ot.delete();
            m_dq.delete();
        end else begin
            m_fire = exp_req_valid() && bus.imem_req_ready;
            if (bus.redirect_valid) begin
                foreach (m_ot[i]) m_ot[i].keep = 1'b0;
                if (bus.imem_rsp_valid && (m_ot.size() > 0)) void'(m_ot.pop_front());
                m_dq.delete();
                m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if ((m_dq.size() > 0) && bus.if_ready) void'(m_dq.pop_front());
                if (bus.imem_rsp_valid) begin
                    chk("rsp_has_request", 32'(m_ot.size() != 0), 32'd1);
                    if (m_ot.size() != 0) begin
                        m_o = m_ot.pop_front();
                        if (m_o.keep) m_dq.push_back({bus.imem_rsp_data, m_o.addr});
                    end
                end
                if (m_fire) begin
                    m_ot.push_back({m_pc, 1'b1});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            e_instr = (m_dq.size() > 0) ? m_dq[0].instr : 32'h0;
            e_pc    = (m_dq.size() > 0) ? m_dq[0].pc : 32'h0;
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_req_valid()));
            chk("req_addr", bus.imem_req_addr, m_pc);
            chk("if_valid", 32'(bus.if_valid), 32'(m_dq.size() > 0));
            chk("if_instr", bus.if_instr, e_instr);
            chk("if_pc", bus.if_pc, e_pc);
            chk("opcode", 32'(bus.opcode), 32'(e_instr[6:0]));
            chk("funct3", 32'(bus.funct3), 32'(e_instr[14:12]));
            chk("funct7", 32'(bus.funct7), 32'(e_instr[31:25]));
        end
    end

    task automatic drive_mem(input logic hold);
        bus.imem_rsp_valid = (pend.size() > 0) && !hold;
        bus.imem_rsp_data  = (pend.size() > 0) ? instr_of(pend[0]) : 32'h0;
    endtask

    task automatic cyc(input logic redir, input logic [31:0] rpc, input logic ifr,
                       input logic rdy, input logic hold);
        @(negedge clk);
        drive_mem(hold);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.if_ready       = ifr;
        bus.imem_req_ready = rdy;
        #3;
    endtask

    // Redirects only when a response and a pop coincide in the same cycle.
    task automatic try_hit(output logic got);
        @(negedge clk);
        drive_mem(1'b0);
        got                = bus.imem_rsp_valid && (m_dq.size() > 0);
        bus.redirect_valid = got;
        bus.redirect_pc    = 32'h0000_0300;
        bus.if_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        #3;
    endtask

    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b1;

        repeat (3) @(negedge clk);
        #3;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("c1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("c1_req_addr", bus.imem_req_addr, 32'h0000_0100);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("c2_req_addr", bus.imem_req_addr, 32'h0000_0104);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("c3_req_addr", bus.imem_req_addr, 32'h0000_0108);
        chk("c3_if_pc", bus.if_pc, 32'h0000_0100);
        chk("c3_if_instr", bus.if_instr, 32'h01C0_FFEE);
        repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Decode stalls: queue fills and credits run out.
        repeat (5) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("stall_if_valid", 32'(bus.if_valid), 32'd1);
        repeat (8) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Two requests outstanding, then redirect.
        repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("hold_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("hold_if_valid", 32'(bus.if_valid), 32'd0);
        cyc(1'b1, 32'h0000_0203, 1'b1, 1'b1, 1'b1);
        chk("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("redir_req_addr", bus.imem_req_addr, 32'h0000_0200);
        chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd1);
        seen = 1'b0;
        for (int k = 0; (k < 12) && !seen; k++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            if (bus.if_valid) begin
                seen = 1'b1;
                chk("redir_first_pc", bus.if_pc, 32'h0000_0200);
            end
        end
        chk("redir_if_valid_seen", 32'(seen), 32'd1);

        // Redirect coinciding with a response and a pop.
        repeat (2) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        hit = 1'b0;
        for (int k = 0; (k < 10) && !hit; k++) try_hit(hit);
        chk("same_cycle_hit_seen", 32'(hit), 32'd1);

        // Memory not ready: address held.
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_if_valid", 32'(bus.if_valid), 32'd0);
        chk("busy_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("busy_addr_0", bus.imem_req_addr, 32'h0000_0300);
        repeat (2) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            chk("busy_addr_held", bus.imem_req_addr, 32'h0000_0300);
        end
        repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        // Address wrap at the top of memory.
        cyc(1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("wrap_req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        chk("wrap_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("bubble_if_valid", 32'(bus.if_valid), 32'd0);
        chk("bubble_opcode", 32'(bus.opcode), 32'd0);
        chk("bubble_funct3", 32'(bus.funct3), 32'd0);
        chk("bubble_funct7", 32'(bus.funct7), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("wrap_next_addr", bus.imem_req_addr, 32'h0000_0000);
        repeat (10) cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
